fp7_alu_add_ctrl: RTL and testbench

//  Issue controller for the fp7 add/sub pipeline (align, mantissa compare, add, normalise stages).

---
 rtl/fp7_alu_add_ctrl_if.sv | 31 +++
 rtl/fp7_alu_add_ctrl.sv | 80 ++++++++
 tb/tb_fp7_alu_add_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fp7_alu_add_ctrl_if.sv
// Handshake and status bundle between the fp7 add/sub issue controller and its
// requesters, datapath stage enables and result FIFO.
interface fp7_alu_add_ctrl_if #(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 3
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  issue_valid;
  logic                  issue_sel;
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic                  res_valid;
  logic                  res_tag;
  logic                  res_pop;
  logic [CNT_W-1:0]      credits;
  logic                  err_ovf;

  modport master (
    output req0_valid, req1_valid, res_pop,
    input  req0_ready, req1_ready, issue_valid, issue_sel, stage_valid,
           res_valid, res_tag, credits, err_ovf
  );

  modport slave (
    input  req0_valid, req1_valid, res_pop,
    output req0_ready, req1_ready, issue_valid, issue_sel, stage_valid,
           res_valid, res_tag, credits, err_ovf
  );
endinterface

// File: rtl/fp7_alu_add_ctrl.sv
// Issue controller for the fp7 add/sub pipeline: round-robin arbitration of two
// requesters, credit-gated issue into a non-stalling valid/tag shift register.
module fp7_alu_add_ctrl #(
  parameter int PIPE_DEPTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  fp7_alu_add_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]      credits_q;
  logic                  last_grant;
  logic                  err_q;
  logic [PIPE_DEPTH-1:0] vld_p;
  logic [PIPE_DEPTH-1:0] tag_p;

  logic                  can_issue;
  logic                  grant;
  logic                  issue;
  logic                  ovf;
  logic                  pop_ok;

  // Credits are taken at issue and returned on pop; a pop at full credits with
  // no issue has nothing to return and is dropped.
  function automatic logic [CNT_W-1:0] credit_next(
    input logic [CNT_W-1:0] cur,
    input logic             take,
    input logic             give
  );
    credit_next = cur - {{(CNT_W-1){1'b0}}, take} + {{(CNT_W-1){1'b0}}, give};
  endfunction

  // Issue stage: arbitration and credit check
  always_comb begin
    can_issue = (credits_q != '0) & ~rst;
    grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    issue     = can_issue & (bus.req0_valid | bus.req1_valid);
    ovf       = bus.res_pop & (credits_q == FULL) & ~issue;
    pop_ok    = bus.res_pop & ~ovf;
  end

  assign bus.issue_valid = issue;
  assign bus.issue_sel   = issue & grant;
  assign bus.req0_ready  = issue & ~grant;
  assign bus.req1_ready  = issue & grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= FULL;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      credits_q <= credit_next(credits_q, issue, pop_ok);
      if (issue) last_grant <= grant;
      if (ovf)   err_q      <= 1'b1;
    end
  end

  // Stage 0..PIPE_DEPTH-1: valid/tag shift register, never stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      tag_p <= '0;
    end else begin
      vld_p <= {vld_p[PIPE_DEPTH-2:0], issue};
      tag_p <= {tag_p[PIPE_DEPTH-2:0], issue & grant};
    end
  end

  assign bus.stage_valid = vld_p;
  assign bus.res_valid   = vld_p[PIPE_DEPTH-1];
  assign bus.res_tag     = tag_p[PIPE_DEPTH-1];
  assign bus.credits     = credits_q;
  assign bus.err_ovf     = err_q;

endmodule

// File: tb/tb_fp7_alu_add_ctrl.sv
// Bench for fp7_alu_add_ctrl: directed scenarios plus protocol-respecting random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_fp7_alu_add_ctrl;
  localparam int PD = 4;
  localparam int FD = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp7_alu_add_ctrl_if #(.PIPE_DEPTH(PD), .CNT_W(CW)) ifc ();

  fp7_alu_add_ctrl #(.PIPE_DEPTH(PD), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: free credits, last winner, sticky error, and a
  // queue of outstanding results (cycle they appear, requester id).
  int m_credits;
  bit m_last;
  bit m_err;
  int cyc;
  int due_q[$];
  bit tag_q[$];
  bit fired0, fired1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_credits = FD;
    m_last    = 1'b1;
    m_err     = 1'b0;
    due_q.delete();
    tag_q.delete();
  endtask

  task automatic cycle(input bit r, input bit v0, input bit v1, input bit pop);
    bit can, g, iss, ovf, exp_rv;
    logic [PD-1:0] exp_sv;
    int k;
    rst            = r;
    ifc.req0_valid = v0;
    ifc.req1_valid = v1;
    ifc.res_pop    = pop;
    @(negedge clk);
    can = (m_credits != 0) && !r;
    g   = (v0 && v1) ? !m_last : v1;
    iss = can && (v0 || v1);
    chk("ready0", ifc.req0_ready, iss && !g);
    chk("ready1", ifc.req1_ready, iss && g);
    chk("issue_valid", ifc.issue_valid, iss);
    if (iss) chk("issue_sel", ifc.issue_sel, g);
    exp_sv = '0;
    foreach (due_q[i]) begin
      k = PD - 1 - (due_q[i] - cyc);
      if (k >= 0 && k < PD) exp_sv[k] = 1'b1;
    end
    chk("stage_valid", ifc.stage_valid, exp_sv);
    exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("res_valid", ifc.res_valid, exp_rv);
    if (exp_rv) chk("res_tag", ifc.res_tag, tag_q[0]);
    chk("credits", ifc.credits, m_credits);
    chk("err_ovf", ifc.err_ovf, m_err);
    @(posedge clk);
    if (exp_rv) begin
      void'(due_q.pop_front());
      void'(tag_q.pop_front());
    end
    fired0 = iss && !g;
    fired1 = iss && g;
    if (r) begin
      model_reset();
    end else begin
      ovf = pop && (m_credits == FD) && !iss;
      if (ovf) m_err = 1'b1;
      m_credits = m_credits - (iss ? 1 : 0) + ((pop && !ovf) ? 1 : 0);
      if (iss) begin
        m_last = g;
        due_q.push_back(cyc + PD);
        tag_q.push_back(g);
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    bit h0, h1, v0, v1;
    cyc = 0;
    rst = 1'b1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.res_pop    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then a single req0 op travelling to the result
    cycle(1, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t1_credits_after_issue", ifc.credits, 3);
    repeat (4) cycle(0, 0, 0, 0);

    // Both valid with pops every cycle: alternating grants
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 1, 1, 1);
    repeat (5) cycle(0, 0, 0, 1);

    // Credit exhaustion, then a single pop lets exactly one more op through
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0);
    chk("t3_credits_zero", ifc.credits, 0);
    chk("t3_ready0_blocked", ifc.req0_ready, 0);
    cycle(0, 1, 0, 1);
    chk("t4_credits_one", ifc.credits, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("t4_credits_back_zero", ifc.credits, 0);

    // Reset with ops in flight drops them
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    chk("t5_credits_full", ifc.credits, FD);

    // Pop at full credits: ignored, sticky error until reset
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);
    chk("t6_err_set", ifc.err_ovf, 1);
    chk("t6_credits_full", ifc.credits, FD);
    cycle(1, 0, 0, 0);
    chk("t6_err_cleared", ifc.err_ovf, 0);

    // Random traffic; requesters hold valid until they fire
    h0 = 1'b0;
    h1 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bit r;
      r  = ($urandom_range(0, 79) == 0);
      v0 = h0 | ($urandom_range(0, 1) == 1);
      v1 = h1 | ($urandom_range(0, 1) == 1);
      cycle(r, v0, v1, $urandom_range(0, 2) == 0);
      h0 = r ? 1'b0 : (v0 && !fired0);
      h1 = r ? 1'b0 : (v1 && !fired1);
    end
    repeat (PD + 1) cycle(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
